pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register for the pipelined LEGv8 core; replaces the per-stage hand-built
//  registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one parametrised block.
//  Carries a valid bit, control bundle, destination register and data payload through DEPTH slots.
//  Adds stall (hold), flush (bubble insert) and saturating stall/bubble performance counters.
// PARAMETERS
//  DATA_W      64         payload width (e.g. Db, Daddr9Ext, ALU result concatenations)
//  CTRL_W      4          control bundle width (MemWrite, MemToReg, FlagWrite, RegWrite, ...)
//  CTRL_BUBBLE '0         control value loaded for a bubble (all write-enables deasserted)
//  DEPTH       1          number of register slots (>=1); DEPTH>1 used for retimed stages
//  CNT_W       16         width of each performance counter
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-high reset
//  in_valid    in   1        upstream stage holds a real instruction
//  in_ctrl     in   CTRL_W   upstream control bundle
//  in_rd       in   5        upstream destination register number
//  in_data     in   DATA_W   upstream payload
//  stall       in   1        hold all slots this cycle
//  flush       in   1        squash all slots this cycle (priority over stall)
//  out_valid   out  1        valid of last slot
//  out_ctrl    out  CTRL_W   control of last slot
//  out_rd      out  5        Rd of last slot
//  out_data    out  DATA_W   payload of last slot
//  stall_cnt   out  CNT_W    cycles spent stalled (saturating)
//  bubble_cnt  out  CNT_W    bubbles inserted into slot 0 (saturating)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. Reset: every slot valid=0, ctrl=CTRL_BUBBLE,
//    rd=5'd31 (XZR), data=0; stall_cnt=0, bubble_cnt=0. Outputs take these values immediately on reset.
//  - Per rising edge, priority flush > stall > advance:
//    flush : all slots valid=0, ctrl=CTRL_BUBBLE, rd=31; data holds. bubble_cnt += 1.
//    stall : all slots hold every field; stall_cnt += 1.
//    advance: slot[i] <= slot[i-1] for i>=1; slot[0] <= inputs.
//      if in_valid=0 on advance: slot[0] gets valid=0, ctrl=CTRL_BUBBLE, rd=31, data=in_data; bubble_cnt += 1.
//  - Invariant: any slot with valid=0 has ctrl==CTRL_BUBBLE and rd==31, so downstream never writes
//    registers/memory/flags from a bubble and forwarding never matches a real Rd (X31 never forwards).
//  - Latency: DEPTH cycles from in_* to out_* when no stall/flush. Outputs are pure slot registers (no comb path
//    from any input to any output).
//  - Counters saturate at 2**CNT_W-1; no wrap. stall and flush together count only toward bubble_cnt.
//  - stall asserted for N consecutive cycles: outputs constant for N cycles, resume advancing next cycle.
//  - Reset asserted mid-stall or mid-flush: reset wins immediately; counters clear.
//  - DEPTH<1 is illegal: elaboration-time $error.
// STRUCTURE
//  - Package pipe_pkg: REG_XZR = 5'd31; typedef of the standard control bundle struct
//    (mem_write, mem_to_reg, flag_write, reg_write) and its CTRL_BUBBLE constant.
//  - Sub-module pipe_slot: one slot (valid/ctrl/rd/data flops, async reset, load/hold/squash select);
//    pipe_stage_reg instantiates DEPTH of them in a generate loop plus two saturating counters.
// TESTING
//  1 Reset: reset=1 mid-run -> out_valid=0, out_ctrl=CTRL_BUBBLE, out_rd=31, out_data=0, counters 0, asynchronously.
//  2 Flow, DEPTH=1: in_valid=1, rd=5, data=64'hDEAD_BEEF, ctrl=4'b1010 -> same values on out_* exactly 1 cycle later;
//    DEPTH=3 -> exactly 3 cycles later, stream of 3 back-to-back values in order.
//  3 Stall: stall=1 for 4 cycles with changing inputs -> out_* frozen 4 cycles, stall_cnt=4, then next input emerges.
//  4 Flush: DEPTH=3 full of valid ops, flush=1 with stall=1 -> next cycle all slots valid=0, rd=31,
//    ctrl=CTRL_BUBBLE, bubble_cnt=1, stall_cnt unchanged.
//  5 Bubble insert: in_valid=0 with in_rd=7, in_ctrl=4'hF -> out_rd=31, out_ctrl=CTRL_BUBBLE, bubble_cnt+1.
//  6 Saturation: CNT_W=3, stall held 10 cycles -> stall_cnt stops at 7 and stays 7.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the LEGv8 inter-stage pipeline registers: zero-register
// number, the standard control bundle and the per-slot update selector.
package pipe_pkg;

    localparam logic [4:0] REG_XZR = 5'd31;

    typedef struct packed {
        logic mem_write;
        logic mem_to_reg;
        logic flag_write;
        logic reg_write;
    } ctrl_t;

    // Bubble control: every write-enable deasserted.
    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        SLOT_LOAD,
        SLOT_HOLD,
        SLOT_SQUASH
    } slot_op_t;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot: valid/ctrl/rd/data flops with load, hold or squash per cycle.
// A squash turns the slot into a bubble but leaves the payload untouched.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 4,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  slot_op_t          op,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [4:0]        d_rd,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [4:0]        q_rd,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_ctrl  <= BUBBLE_CTRL;
            q_rd    <= REG_XZR;
            q_data  <= '0;
        end else begin
            unique case (op)
                SLOT_LOAD: begin
                    q_valid <= d_valid;
                    q_ctrl  <= d_ctrl;
                    q_rd    <= d_rd;
                    q_data  <= d_data;
                end
                SLOT_SQUASH: begin
                    q_valid <= 1'b0;
                    q_ctrl  <= BUBBLE_CTRL;
                    q_rd    <= REG_XZR;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots with stall/flush and
// saturating stall and bubble counters. Outputs come straight from the last slot.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 4,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(pipe_pkg::CTRL_BUBBLE),
    parameter int                DEPTH       = 1,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("pipe_stage_reg: DEPTH must be >= 1");
    end

    localparam int N = (DEPTH < 1) ? 1 : DEPTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_pkg::slot_op_t op;

    always_comb begin
        op = pipe_pkg::SLOT_LOAD;
        if (flush) begin
            op = pipe_pkg::SLOT_SQUASH;
        end else if (stall) begin
            op = pipe_pkg::SLOT_HOLD;
        end
    end

    // An idle upstream enters as a bubble so the invariant holds from slot 0 on.
    logic [CTRL_W-1:0] head_ctrl;
    logic [4:0]        head_rd;
    assign head_ctrl = in_valid ? in_ctrl : CTRL_BUBBLE;
    assign head_rd   = in_valid ? in_rd : pipe_pkg::REG_XZR;

    logic [N-1:0]      slot_valid;
    logic [CTRL_W-1:0] slot_ctrl [N];
    logic [4:0]        slot_rd   [N];
    logic [DATA_W-1:0] slot_data [N];

    for (genvar i = 0; i < N; i++) begin : g_slot
        if (i == 0) begin : g_head
            pipe_slot #(
                .DATA_W      (DATA_W),
                .CTRL_W      (CTRL_W),
                .BUBBLE_CTRL (CTRL_BUBBLE)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .op      (op),
                .d_valid (in_valid),
                .d_ctrl  (head_ctrl),
                .d_rd    (head_rd),
                .d_data  (in_data),
                .q_valid (slot_valid[i]),
                .q_ctrl  (slot_ctrl[i]),
                .q_rd    (slot_rd[i]),
                .q_data  (slot_data[i])
            );
        end else begin : g_tail
            pipe_slot #(
                .DATA_W      (DATA_W),
                .CTRL_W      (CTRL_W),
                .BUBBLE_CTRL (CTRL_BUBBLE)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .op      (op),
                .d_valid (slot_valid[i-1]),
                .d_ctrl  (slot_ctrl[i-1]),
                .d_rd    (slot_rd[i-1]),
                .d_data  (slot_data[i-1]),
                .q_valid (slot_valid[i]),
                .q_ctrl  (slot_ctrl[i]),
                .q_rd    (slot_rd[i]),
                .q_data  (slot_data[i])
            );
        end
    end

    assign out_valid = slot_valid[N-1];
    assign out_ctrl  = slot_ctrl[N-1];
    assign out_rd    = slot_rd[N-1];
    assign out_data  = slot_data[N-1];

    // Flush outranks stall, so a combined stall+flush is only a bubble.
    logic stall_inc;
    logic bubble_inc;
    assign stall_inc  = stall && !flush;
    assign bubble_inc = flush || (!stall && !in_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bubble_inc && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH=1 vector table, DEPTH=3 scoreboard stream,
// stall/flush sequences, counter saturation and asynchronous reset.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset    = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_ctrl  = '0;
    logic [4:0]  in_rd    = '0;
    logic [63:0] in_data  = '0;
    logic stall1 = 1'b0, flush1 = 1'b0;
    logic stall3 = 1'b0, flush3 = 1'b0;
    logic stall_s = 1'b0, flush_s = 1'b0;

    logic        out1_valid, out3_valid, outs_valid;
    logic [3:0]  out1_ctrl, out3_ctrl, outs_ctrl;
    logic [4:0]  out1_rd, out3_rd, outs_rd;
    logic [63:0] out1_data, out3_data, outs_data;
    logic [15:0] stall1_cnt, bubble1_cnt, stall3_cnt, bubble3_cnt;
    logic [2:0]  stalls_cnt, bubbles_cnt;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .DEPTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .in_data(in_data), .stall(stall1), .flush(flush1), .out_valid(out1_valid),
        .out_ctrl(out1_ctrl), .out_rd(out1_rd), .out_data(out1_data),
        .stall_cnt(stall1_cnt), .bubble_cnt(bubble1_cnt));

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .DEPTH(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .in_data(in_data), .stall(stall3), .flush(flush3), .out_valid(out3_valid),
        .out_ctrl(out3_ctrl), .out_rd(out3_rd), .out_data(out3_data),
        .stall_cnt(stall3_cnt), .bubble_cnt(bubble3_cnt));

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .DEPTH(1), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_rd(in_rd),
        .in_data(in_data), .stall(stall_s), .flush(flush_s), .out_valid(outs_valid),
        .out_ctrl(outs_ctrl), .out_rd(outs_rd), .out_data(outs_data),
        .stall_cnt(stalls_cnt), .bubble_cnt(bubbles_cnt));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic v; logic [3:0] c; logic [4:0] rd; logic [63:0] d; logic st; logic fl;
        logic ev; logic [3:0] ec; logic [4:0] erd; logic [63:0] ed; int unsigned est; int unsigned ebu;
    } vec_t;

    typedef struct packed {
        logic v; logic [3:0] c; logic [4:0] rd; logic [63:0] d;
    } exp_t;

    exp_t        sb_q[$];
    bit          sb_on    = 1'b0;
    int unsigned exp_bub3 = 0;

    task automatic step();
        exp_t e;
        if (flush3) exp_bub3++;
        else if (!stall3 && !in_valid) exp_bub3++;
        if (sb_on && !stall3 && !flush3) begin
            e.v  = in_valid;
            e.c  = in_valid ? in_ctrl : 4'h0;
            e.rd = in_valid ? in_rd : 5'd31;
            e.d  = in_data;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("d3_bubble_cnt", bubble3_cnt, 64'(exp_bub3));
        if (sb_on && sb_q.size() == 3) begin
            e = sb_q.pop_front();
            check("d3_out_valid", out3_valid, e.v);
            check("d3_out_ctrl", out3_ctrl, e.c);
            check("d3_out_rd", out3_rd, e.rd);
            check("d3_out_data", out3_data, e.d);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [4:0] rd, input logic [63:0] d);
        in_valid = v; in_ctrl = c; in_rd = rd; in_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [8];
        int unsigned exp_sat;

        tbl[0] = '{1'b1, 4'hA, 5'd5,  64'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 4'hA, 5'd5,  64'hDEAD_BEEF, 0, 0};
        tbl[1] = '{1'b1, 4'h3, 5'd12, 64'h1234,      1'b0, 1'b0, 1'b1, 4'h3, 5'd12, 64'h1234,      0, 0};
        tbl[2] = '{1'b1, 4'hF, 5'd9,  64'h55,        1'b1, 1'b0, 1'b1, 4'h3, 5'd12, 64'h1234,      1, 0};
        tbl[3] = '{1'b0, 4'hF, 5'd7,  64'h77,        1'b0, 1'b0, 1'b0, 4'h0, 5'd31, 64'h77,        1, 1};
        tbl[4] = '{1'b1, 4'h5, 5'd3,  64'h99,        1'b1, 1'b1, 1'b0, 4'h0, 5'd31, 64'h77,        1, 2};
        tbl[5] = '{1'b1, 4'h6, 5'd4,  64'hAA,        1'b0, 1'b0, 1'b1, 4'h6, 5'd4,  64'hAA,        1, 2};
        tbl[6] = '{1'b1, 4'h8, 5'd2,  64'hBB,        1'b0, 1'b1, 1'b0, 4'h0, 5'd31, 64'hAA,        1, 3};
        tbl[7] = '{1'b1, 4'h9, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 4'h9, 5'd30,
                   64'hFFFF_FFFF_FFFF_FFFF, 1, 3};

        // Reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #2;
        check("rst_valid", out1_valid, 1'b0);
        check("rst_ctrl", out1_ctrl, 4'h0);
        check("rst_rd", out1_rd, 5'd31);
        check("rst_data", out1_data, 64'h0);
        check("rst_stall_cnt", stall1_cnt, 16'h0);
        check("rst_bubble_cnt", bubble1_cnt, 16'h0);
        check("rst_d3_rd", out3_rd, 5'd31);
        @(posedge clk);
        #1 reset = 1'b0;

        sb_on = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].rd, tbl[i].d);
            stall1 = tbl[i].st;
            flush1 = tbl[i].fl;
            step();
            check($sformatf("vec%0d_valid", i), out1_valid, tbl[i].ev);
            check($sformatf("vec%0d_ctrl", i), out1_ctrl, tbl[i].ec);
            check($sformatf("vec%0d_rd", i), out1_rd, tbl[i].erd);
            check($sformatf("vec%0d_data", i), out1_data, tbl[i].ed);
            check($sformatf("vec%0d_stall_cnt", i), stall1_cnt, 64'(tbl[i].est));
            check($sformatf("vec%0d_bubble_cnt", i), bubble1_cnt, 64'(tbl[i].ebu));
        end
        stall1 = 1'b0;
        flush1 = 1'b0;

        // Four-cycle stall with changing inputs on the DEPTH=1 instance.
        drive(1'b1, 4'h2, 5'd17, 64'h0123_4567_89AB_CDEF);
        step();
        check("pre_stall_rd", out1_rd, 5'd17);
        for (int unsigned k = 0; k < 4; k++) begin
            stall1 = 1'b1;
            drive(1'b1, 4'(k + 4), 5'(k + 1), 64'(k * 32'h1111));
            step();
            check("stall_valid", out1_valid, 1'b1);
            check("stall_rd", out1_rd, 5'd17);
            check("stall_data", out1_data, 64'h0123_4567_89AB_CDEF);
            check("stall_cnt_run", stall1_cnt, 64'(2 + k));
        end
        stall1 = 1'b0;
        drive(1'b1, 4'h1, 5'd22, 64'h5555);
        step();
        check("post_stall_rd", out1_rd, 5'd22);
        check("post_stall_data", out1_data, 64'h5555);
        check("post_stall_cnt", stall1_cnt, 16'd5);

        // Fill DEPTH=3 with valid ops, then flush together with stall.
        for (int unsigned k = 0; k < 3; k++) begin
            drive(1'b1, 4'hC, 5'(10 + k), 64'(100 + k));
            step();
        end
        sb_on = 1'b0;
        sb_q.delete();
        flush3 = 1'b1;
        stall3 = 1'b1;
        drive(1'b1, 4'hE, 5'd20, 64'h200);
        step();
        check("flush_valid", out3_valid, 1'b0);
        check("flush_ctrl", out3_ctrl, 4'h0);
        check("flush_rd", out3_rd, 5'd31);
        check("flush_stall_cnt", stall3_cnt, 16'h0);
        flush3 = 1'b0;
        stall3 = 1'b0;
        for (int unsigned k = 0; k < 2; k++) begin
            drive(1'b1, 4'hB, 5'd21, 64'h300);
            step();
            check("flushed_slot_valid", out3_valid, 1'b0);
            check("flushed_slot_rd", out3_rd, 5'd31);
        end

        // Three-bit stall counter held for ten cycles.
        for (int unsigned k = 0; k < 10; k++) begin
            stall_s = 1'b1;
            step();
            exp_sat = (k + 1 > 7) ? 7 : k + 1;
            check("sat_stall_cnt", stalls_cnt, 64'(exp_sat));
        end

        // Reset mid-stall, away from any clock edge.
        stall1 = 1'b1;
        #3 reset = 1'b1;
        #1;
        check("mid_rst_valid", out1_valid, 1'b0);
        check("mid_rst_ctrl", out1_ctrl, 4'h0);
        check("mid_rst_rd", out1_rd, 5'd31);
        check("mid_rst_data", out1_data, 64'h0);
        check("mid_rst_stall_cnt", stall1_cnt, 16'h0);
        check("mid_rst_bubble_cnt", bubble1_cnt, 16'h0);
        check("mid_rst_sat_cnt", stalls_cnt, 3'h0);
        check("mid_rst_d3_valid", out3_valid, 1'b0);
        #5 reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
